conv_layer: RTL

CONV_LAYER -- requirements
Module: conv_layer

---
 rtl/cnn_pkg.sv | 37 +++
 rtl/mac_unit.sv | 38 +++
 rtl/conv_layer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN layer constants, conv FSM states and the accumulator-to-data saturator.
`timescale 1ns/1ps
package cnn_pkg;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 72;
    localparam int FM_W   = 8;
    localparam int K_W    = 3;
    localparam int OUT_W  = FM_W - K_W + 1;
    localparam int N_IN   = FM_W * FM_W;
    localparam int N_TAPS = K_W * K_W;
    localparam int N_OUT  = OUT_W * OUT_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MAC,
        ST_SCALE,
        ST_WRITE,
        ST_DONE
    } conv_state_t;

    function automatic logic [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        logic [DATA_W-1:0]       res;
        hi = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        lo = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
        if (v > hi) begin
            res = hi[DATA_W-1:0];
        end else if (v < lo) begin
            res = lo[DATA_W-1:0];
        end else begin
            res = v[DATA_W-1:0];
        end
        return res;
    endfunction
endpackage

// File: rtl/mac_unit.sv
// Signed 32x32 multiply into a 72-bit accumulator; clear wins over enable.
`timescale 1ns/1ps
module mac_unit
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  acc_o
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    assign prod = $signed(a_i) * $signed(b_i);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/conv_layer.sv
// 3x3 valid convolution of an 8x8 map, one tap per cycle (12 cycles/pixel, 432 per frame).
// Inputs are read live during the run, so they must stay stable until done.
`timescale 1ns/1ps
module conv_layer
    import cnn_pkg::*;
#(
    parameter int FRAC_BITS = 0,
    parameter bit RELU_EN   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_IN*DATA_W-1:0]   input_fm,
    input  logic [N_TAPS*DATA_W-1:0] kernel,
    input  logic [DATA_W-1:0]        bias,
    output logic                     done,
    output logic [N_OUT*DATA_W-1:0]  output_fm
);
    conv_state_t state_q, state_d;
    logic [2:0]        row_q, row_d;
    logic [2:0]        col_q, col_d;
    logic [3:0]        k_q, k_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [N_OUT-1:0][DATA_W-1:0] ofm_q;

    logic [N_IN-1:0][DATA_W-1:0]   fm_arr;
    logic [N_TAPS-1:0][DATA_W-1:0] k_arr;
    logic [1:0]        tap_r, tap_c;
    logic [3:0]        tap_r3;
    logic [5:0]        pix_idx, wr_idx;
    logic              mac_clr, mac_en, wr_en;
    logic [ACC_W-1:0]  acc;

    logic signed [ACC_W-1:0] bias_ext, sum_w, shr_w;
    logic [DATA_W-1:0]       sat_w, scaled_w;

    assign fm_arr = input_fm;
    assign k_arr  = kernel;

    // Tap k maps to kernel row k/3 and column k%3 without a divider.
    always_comb begin
        tap_r   = (k_q >= 4'd6) ? 2'd2 : ((k_q >= 4'd3) ? 2'd1 : 2'd0);
        tap_r3  = {1'b0, tap_r, 1'b0} + {2'b00, tap_r};
        tap_c   = 2'(k_q - tap_r3);
        pix_idx = {3'(row_q + {1'b0, tap_r}), 3'(col_q + {1'b0, tap_c})};
        wr_idx  = {3'b000, row_q} * 6'd6 + {3'b000, col_q};
    end

    mac_unit u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (fm_arr[pix_idx]),
        .b_i   (k_arr[k_q]),
        .acc_o (acc)
    );

    // Bias is aligned to the accumulator's fraction before one floor shift.
    always_comb begin
        bias_ext = ACC_W'($signed(bias));
        sum_w    = $signed(acc) + (bias_ext <<< FRAC_BITS);
        shr_w    = sum_w >>> FRAC_BITS;
        sat_w    = sat_data(shr_w);
        scaled_w = (RELU_EN && sat_w[DATA_W-1]) ? '0 : sat_w;
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        k_d     = k_q;
        done_d  = done_q;
        res_d   = res_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    row_d   = '0;
                    col_d   = '0;
                    done_d  = 1'b0;
                end
            end
            ST_CLEAR: begin
                mac_clr = 1'b1;
                k_d     = '0;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (k_q == 4'(N_TAPS-1)) begin
                    k_d     = '0;
                    state_d = ST_SCALE;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            ST_SCALE: begin
                res_d   = scaled_w;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wr_en = 1'b1;
                if (col_q != 3'(OUT_W-1)) begin
                    col_d   = col_q + 3'd1;
                    state_d = ST_CLEAR;
                end else if (row_q != 3'(OUT_W-1)) begin
                    col_d   = '0;
                    row_d   = row_q + 3'd1;
                    state_d = ST_CLEAR;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Leaving only on start low keeps a held start from retriggering.
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
            ofm_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            k_q     <= k_d;
            done_q  <= done_d;
            res_q   <= res_d;
            if (wr_en) begin
                ofm_q[wr_idx] <= res_q;
            end
        end
    end

    assign done      = done_q;
    assign output_fm = ofm_q;
endmodule
